// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared constants for the LED-matrix scan controller: state encodings,
// default geometry and a width helper for counters.
package matrix_scan_ctrl_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;
    localparam int ROW_W    = $clog2(ROWS_DEF);

    // Scan phase encodings
    localparam logic [0:0] SCAN_BLANK = 1'b0;
    localparam logic [0:0] SCAN_DRIVE = 1'b1;

    // Clear sequencer encodings
    localparam logic [0:0] CLR_IDLE  = 1'b0;
    localparam logic [0:0] CLR_CLEAR = 1'b1;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_scan_timer.sv
// Free-running BLANK/DRIVE dwell counter and row counter. Exposes the next
// phase/row so the parent can register its outputs aligned with the state,
// and flags the last DRIVE cycle of the last row as the frame tick.
module matrix_scan_ctrl_scan_timer
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [0:0]                    phase_next,
    output logic [cnt_width(ROWS)-1:0]    row_next,
    output logic                          frame_tick
);

    localparam int RW   = cnt_width(ROWS);
    localparam int TMAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int TW   = cnt_width(TMAX);

    logic [0:0]    phase_reg;
    logic [RW-1:0] row_reg;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;

    // Next-state: count dwell in each phase, advance row at end of DRIVE
    always_comb begin
        phase_next = phase_reg;
        row_next   = row_reg;
        timer_next = timer_reg + 1'b1;
        frame_tick = 1'b0;
        if (phase_reg == SCAN_BLANK) begin
            if (timer_reg == TW'(BLANK_CYCLES - 1)) begin
                phase_next = SCAN_DRIVE;
                timer_next = '0;
            end
        end else if (timer_reg == TW'(DWELL - 1)) begin
            phase_next = SCAN_BLANK;
            timer_next = '0;
            if (row_reg == RW'(ROWS - 1)) begin
                row_next   = '0;
                frame_tick = 1'b1;
            end else begin
                row_next = row_reg + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg <= SCAN_BLANK;
            row_reg   <= '0;
            timer_reg <= '0;
        end else begin
            phase_reg <= phase_next;
            row_reg   <= row_next;
            timer_reg <= timer_next;
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 8x8 LED-matrix row store. The game writes into the back
// buffer; the scanner displays the front buffer, which is refreshed from the
// back buffer only at frame boundaries. Also sequences multi-cycle clears and
// parks writes that collide with a clear in a one-entry pending register.
module matrix_scan_ctrl
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COLS-1:0]   wr_data,
    input  logic              clr,
    output logic              clr_busy,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_out,
    output logic              frame_tick,
    output logic              wr_overrun
);

    localparam int RW = cnt_width(ROWS);
    localparam int IW = (RW > ROW_W) ? RW : ROW_W;

    logic [COLS-1:0]  back_reg  [ROWS];
    logic [COLS-1:0]  front_reg [ROWS];
    logic [0:0]       clr_state_reg;
    logic [RW-1:0]    crow_reg;
    logic             dirty_reg;
    logic             pend_valid_reg;
    logic [ROW_W-1:0] pend_row_reg;
    logic [COLS-1:0]  pend_data_reg;
    logic             overrun_reg;

    logic [0:0]       phase_next;
    logic [RW-1:0]    row_next;

    logic             in_idle;
    logic             capture;
    logic             direct_wr;
    logic             pend_apply;
    logic             bw_en;
    logic [IW-1:0]    bw_row;
    logic [COLS-1:0]  bw_data;
    logic [ROWS-1:0]  row_hit;
    logic             copy;

    matrix_scan_ctrl_scan_timer #(
        .ROWS         (ROWS),
        .DWELL        (DWELL),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk        (clk),
        .reset      (reset),
        .phase_next (phase_next),
        .row_next   (row_next),
        .frame_tick (frame_tick)
    );

    assign in_idle    = (clr_state_reg == CLR_IDLE);
    assign capture    = wr_en && (!in_idle || clr);
    assign direct_wr  = in_idle && wr_en && !clr;
    assign pend_apply = in_idle && pend_valid_reg && !wr_en && !clr;
    assign copy       = frame_tick && dirty_reg;
    assign clr_busy   = !in_idle;
    assign wr_overrun = overrun_reg;

    // Single back-buffer write port: clear beats direct write beats pending
    always_comb begin
        bw_en   = 1'b0;
        bw_row  = '0;
        bw_data = '0;
        if (!in_idle) begin
            bw_en  = 1'b1;
            bw_row = IW'(crow_reg);
        end else if (direct_wr) begin
            bw_en   = 1'b1;
            bw_row  = IW'(wr_row);
            bw_data = wr_data;
        end else if (pend_apply) begin
            bw_en   = 1'b1;
            bw_row  = IW'(pend_row_reg);
            bw_data = pend_data_reg;
        end
    end

    // Per-row write decode; indices beyond ROWS match nothing and are dropped
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_hit
        assign row_hit[gi] = bw_en && (bw_row == IW'(gi));
    end

    // Back/front buffers; copy samples back before this cycle's write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                back_reg[i]  <= '0;
                front_reg[i] <= '0;
            end
            dirty_reg <= 1'b0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (row_hit[i]) back_reg[i] <= bw_data;
                if (copy)       front_reg[i] <= back_reg[i];
            end
            if (|row_hit)  dirty_reg <= 1'b1;
            else if (copy) dirty_reg <= 1'b0;
        end
    end

    // Clear sequencer; a fresh clr restarts the sweep from row 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_state_reg <= CLR_IDLE;
            crow_reg      <= '0;
        end else if (clr_state_reg == CLR_IDLE) begin
            if (clr) begin
                clr_state_reg <= CLR_CLEAR;
                crow_reg      <= '0;
            end
        end else if (clr) begin
            crow_reg <= '0;
        end else if (crow_reg == RW'(ROWS - 1)) begin
            clr_state_reg <= CLR_IDLE;
            crow_reg      <= '0;
        end else begin
            crow_reg <= crow_reg + 1'b1;
        end
    end

    // Pending write holder; losing an unapplied entry raises sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_reg <= 1'b0;
            pend_row_reg   <= '0;
            pend_data_reg  <= '0;
            overrun_reg    <= 1'b0;
        end else if (capture) begin
            pend_valid_reg <= 1'b1;
            pend_row_reg   <= wr_row;
            pend_data_reg  <= wr_data;
            if (pend_valid_reg) overrun_reg <= 1'b1;
        end else if (pend_apply) begin
            pend_valid_reg <= 1'b0;
        end
    end

    // Registered row/column drive, aligned with the scan state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_sel <= '0;
            col_out <= '0;
        end else if (phase_next == SCAN_DRIVE) begin
            row_sel <= ROWS'(1) << row_next;
            col_out <= front_reg[row_next];
        end else begin
            row_sel <= '0;
            col_out <= '0;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with a short frame (DWELL=6,
// BLANK_CYCLES=2: 8 cycles per row, 64 per frame). Cycle numbers count from
// the first clock period after reset release; inputs are driven and outputs
// sampled 1 time unit after the falling edge.
module tb_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       clr = 1'b0;
    logic       clr_busy;
    logic [7:0] row_sel;
    logic [7:0] col_out;
    logic       frame_tick;
    logic       wr_overrun;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    matrix_scan_ctrl #(
        .ROWS         (8),
        .COLS         (8),
        .DWELL        (6),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .clr        (clr),
        .clr_busy   (clr_busy),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .frame_tick (frame_tick),
        .wr_overrun (wr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       wr_en;
        logic [2:0] wr_row;
        logic [7:0] wr_data;
        logic       clr;
        logic [7:0] e_row_sel;
        logic [7:0] e_col;
        logic       e_tick;
        logic       e_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        wr_en   = 1'b0;
        clr     = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic pulse_wr(input logic [2:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        // Scan timing from reset plus a single write crossing a frame boundary
        vecs[0]  = '{0,   1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1,   1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{2,   1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{7,   1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8,   1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{9,   1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{10,  1'b1, 3'd3, 8'hE0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{28,  1'b0, 3'd0, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{62,  1'b0, 3'd0, 8'h00, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{63,  1'b0, 3'd0, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{64,  1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{66,  1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{92,  1'b0, 3'd0, 8'h00, 1'b0, 8'h08, 8'hE0, 1'b0, 1'b0};
        vecs[13] = '{100, 1'b0, 3'd0, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0};

        // Values while held in reset
        #12;
        chk("rst_row_sel", row_sel, 8'h00);
        chk("rst_col_out", col_out, 8'h00);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_overrun", wr_overrun, 1'b0);

        // ---- Table-driven scan and single-write checks ----
        do_reset();
        for (int i = 0; i < 14; i++) begin
            wait_to(vecs[i].cyc);
            wr_en = vecs[i].wr_en; wr_row = vecs[i].wr_row;
            wr_data = vecs[i].wr_data; clr = vecs[i].clr;
            $display("vec %0d cyc=%0d row_sel=%h col_out=%h tick=%b busy=%b",
                     i, cyc, row_sel, col_out, frame_tick, clr_busy);
            chk("tab_row_sel", row_sel, vecs[i].e_row_sel);
            chk("tab_col_out", col_out, vecs[i].e_col);
            chk("tab_tick", frame_tick, vecs[i].e_tick);
            chk("tab_busy", clr_busy, vecs[i].e_busy);
            step();
            wr_en = 1'b0; clr = 1'b0;
        end

        // ---- Preload all rows, display, clear, display zeros ----
        do_reset();
        for (int r = 0; r < 8; r++) pulse_wr(3'(r), 8'hFF);
        wait_to(66);  chk("pre_row0", col_out, 8'hFF);
        wait_to(106); chk("pre_row5", col_out, 8'hFF); chk("pre_sel5", row_sel, 8'h20);
        wait_to(110); chk("clr_busy_before", clr_busy, 1'b0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_busy_first", clr_busy, 1'b1);
        wait_to(118); chk("clr_busy_last", clr_busy, 1'b1);
        wait_to(119); chk("clr_busy_done", clr_busy, 1'b0);
        wait_to(122); chk("front_held_row7", col_out, 8'hFF);
        wait_to(130); chk("cleared_row0", col_out, 8'h00); chk("cleared_sel0", row_sel, 8'h01);
        wait_to(186); chk("cleared_row7", col_out, 8'h00); chk("cleared_sel7", row_sel, 8'h80);
        $display("txn preload/clear done cyc=%0d", cyc);

        // ---- Write coincident with clr, then held clr ----
        do_reset();
        wait_to(5);
        clr = 1'b1; wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'h1C;
        step();
        clr = 1'b0; wr_en = 1'b0;
        chk("coinc_busy_first", clr_busy, 1'b1);
        wait_to(13); chk("coinc_busy_last", clr_busy, 1'b1);
        wait_to(14); chk("coinc_busy_done", clr_busy, 1'b0);
        wait_to(20); chk("coinc_overrun", wr_overrun, 1'b0);
        wait_to(58); chk("coinc_f0_row7", col_out, 8'h00);
        wait_to(70);
        clr = 1'b1;
        wait_to(75);
        clr = 1'b0;
        wait_to(82); chk("held_busy_last", clr_busy, 1'b1);
        wait_to(83); chk("held_busy_done", clr_busy, 1'b0);
        wait_to(122); chk("coinc_f1_row7", col_out, 8'h1C); chk("coinc_f1_sel", row_sel, 8'h80);
        wait_to(186); chk("held_f2_row7", col_out, 8'h00);
        $display("txn coincident/held clear done cyc=%0d", cyc);

        // ---- Two writes during one clear: last wins, overrun sticks ----
        do_reset();
        wait_to(5);  clr = 1'b1; step(); clr = 1'b0;
        wait_to(7);  pulse_wr(3'd2, 8'hAA);
        chk("ovr_after_first", wr_overrun, 1'b0);
        wait_to(9);  pulse_wr(3'd2, 8'h55);
        chk("ovr_after_second", wr_overrun, 1'b1);
        wait_to(84);
        chk("ovr_row2", col_out, 8'h55); chk("ovr_sel2", row_sel, 8'h04);
        chk("ovr_sticky", wr_overrun, 1'b1);
        $display("txn overrun done cyc=%0d", cyc);

        // ---- Async reset mid-DRIVE of row 5 during a clear ----
        wait_to(105); clr = 1'b1; step(); clr = 1'b0;
        wait_to(108);
        chk("mid_sel5", row_sel, 8'h20);
        chk("mid_busy", clr_busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_row_sel", row_sel, 8'h00);
        chk("async_col_out", col_out, 8'h00);
        chk("async_busy", clr_busy, 1'b0);
        chk("async_tick", frame_tick, 1'b0);
        chk("async_overrun", wr_overrun, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        chk("rel_row_sel", row_sel, 8'h00);
        chk("rel_busy", clr_busy, 1'b0);
        wait_to(1);  chk("rel_blank1", row_sel, 8'h00);
        wait_to(2);  chk("rel_row0", row_sel, 8'h01); chk("rel_col0", col_out, 8'h00);
        wait_to(10); chk("rel_row1", row_sel, 8'h02); chk("rel_overrun", wr_overrun, 1'b0);
        $display("txn async reset done cyc=%0d", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
